// File: rtl/d3s_trig_out_gen.sv
// -----------------------------------------------------------------------------
// d3s_trig_out_gen
// Trigger-pulse transmitter for the D3S core. The host arms it with a target
// RF-counter value; when the local RF counter equals that target, a pulse of
// g_pulse_width clk_ref_i cycles is emitted on trig_p_o. The WR TAI-cycles
// value at the match cycle is captured on snapshot_o.
//
// Ports
//   clk_ref_i       WR reference clock (single clock domain)
//   rst_i           synchronous reset, active high
//   arm_p_i         single-cycle arm request (target_i sampled here)
//   abort_p_i       single-cycle abort request (wins over arm_p_i)
//   target_i        RF count at which to fire
//   period_i        RF counter period; arm rejected when target_i >= period_i
//   rf_cnt_i        current RF counter value
//   rf_cnt_valid_i  RF counter valid; matching is suppressed while low
//   tm_cycles_i     WR TAI cycles counter
//   trig_p_o        trigger pulse
//   armed_o         high while waiting for the target
//   done_o          sticky: pulse emitted since last arm
//   error_o         sticky: last arm rejected
//   snapshot_o      tm_cycles_i captured at the match cycle
// -----------------------------------------------------------------------------
module d3s_trig_out_gen #(
   parameter int unsigned g_rf_cnt_width = 32,
   parameter int unsigned g_pulse_width  = 8,
   parameter int unsigned g_cycles_width = 28
) (
   input  logic                      clk_ref_i,
   input  logic                      rst_i,
   input  logic                      arm_p_i,
   input  logic                      abort_p_i,
   input  logic [g_rf_cnt_width-1:0] target_i,
   input  logic [g_rf_cnt_width-1:0] period_i,
   input  logic [g_rf_cnt_width-1:0] rf_cnt_i,
   input  logic                      rf_cnt_valid_i,
   input  logic [g_cycles_width-1:0] tm_cycles_i,
   output logic                      trig_p_o,
   output logic                      armed_o,
   output logic                      done_o,
   output logic                      error_o,
   output logic [g_cycles_width-1:0] snapshot_o
);

   localparam int unsigned c_cnt_width = (g_pulse_width > 1) ? $clog2(g_pulse_width) : 1;
   localparam logic [c_cnt_width-1:0] c_cnt_load = c_cnt_width'(g_pulse_width - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   state_t                    state_q,  state_d;
   logic [g_rf_cnt_width-1:0] target_q, target_d;
   logic [c_cnt_width-1:0]    cnt_q,    cnt_d;
   logic                      trig_q,   trig_d;
   logic                      armed_q,  armed_d;
   logic                      done_q,   done_d;
   logic                      error_q,  error_d;
   logic [g_cycles_width-1:0] snap_q,   snap_d;

   logic match_c;
   logic arm_ok_c;

   // Equality only: a target already passed fires on the next wrap.
   assign match_c  = rf_cnt_valid_i && (rf_cnt_i == target_q);
   assign arm_ok_c = (target_i < period_i);

   // State and output registers.
   always_ff @(posedge clk_ref_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         cnt_q    <= '0;
         trig_q   <= 1'b0;
         armed_q  <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         snap_q   <= '0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
         trig_q   <= trig_d;
         armed_q  <= armed_d;
         done_q   <= done_d;
         error_q  <= error_d;
         snap_q   <= snap_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      error_d  = error_q;
      snap_d   = snap_q;

      case (state_q)
         ST_IDLE: begin
            // Abort in the same cycle cancels the arm request.
            if (arm_p_i && !abort_p_i) begin
               done_d = 1'b0;
               if (arm_ok_c) begin
                  target_d = target_i;
                  error_d  = 1'b0;
                  state_d  = ST_ARMED;
               end else begin
                  error_d  = 1'b1;
               end
            end
         end

         ST_ARMED: begin
            if (abort_p_i) begin
               state_d = ST_IDLE;
            end else if (match_c) begin
               snap_d  = tm_cycles_i;
               cnt_d   = c_cnt_load;
               state_d = ST_PULSE;
            end
         end

         ST_PULSE: begin
            // Pulse always runs to completion; arm/abort are ignored here.
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - c_cnt_width'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the next state so they are registered with it.
      trig_d  = (state_d == ST_PULSE);
      armed_d = (state_d == ST_ARMED);
   end

   assign trig_p_o   = trig_q;
   assign armed_o    = armed_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign snapshot_o = snap_q;

endmodule

// File: tb/tb_d3s_trig_out_gen.sv
// -----------------------------------------------------------------------------
// tb_d3s_trig_out_gen
// Self-checking bench for d3s_trig_out_gen. A window-based reference model
// (fire cycle index + pulse width) predicts every output after every edge;
// a vector table and directed sequences cover the corner cases, followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_d3s_trig_out_gen;

   localparam int unsigned RW = 32;
   localparam int unsigned PW = 8;
   localparam int unsigned CW = 28;

   logic          clk_ref_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          arm_p_i = 1'b0;
   logic          abort_p_i = 1'b0;
   logic [RW-1:0] target_i = '0;
   logic [RW-1:0] period_i = '0;
   logic [RW-1:0] rf_cnt_i = '0;
   logic          rf_cnt_valid_i = 1'b0;
   logic [CW-1:0] tm_cycles_i = '0;
   logic          trig_p_o;
   logic          armed_o;
   logic          done_o;
   logic          error_o;
   logic [CW-1:0] snapshot_o;

   d3s_trig_out_gen #(
      .g_rf_cnt_width (RW),
      .g_pulse_width  (PW),
      .g_cycles_width (CW)
   ) dut (
      .clk_ref_i      (clk_ref_i),
      .rst_i          (rst_i),
      .arm_p_i        (arm_p_i),
      .abort_p_i      (abort_p_i),
      .target_i       (target_i),
      .period_i       (period_i),
      .rf_cnt_i       (rf_cnt_i),
      .rf_cnt_valid_i (rf_cnt_valid_i),
      .tm_cycles_i    (tm_cycles_i),
      .trig_p_o       (trig_p_o),
      .armed_o        (armed_o),
      .done_o         (done_o),
      .error_o        (error_o),
      .snapshot_o     (snapshot_o)
   );

   always #5 clk_ref_i = ~clk_ref_i;

   int checks = 0;
   int errors = 0;

   // Reference model: the pulse is the window of PW edges starting at the
   // edge where the match was sampled.
   int            edge_n  = 0;
   bit            m_armed = 0;
   bit            m_done  = 0;
   bit            m_err   = 0;
   bit            m_fv    = 0;
   int            m_fire  = 0;
   logic [RW-1:0] m_tgt   = '0;
   logic [CW-1:0] m_snap  = '0;
   logic [CW-1:0] tm_ctr  = 28'd1000;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic bit m_trig();
      return m_fv && (edge_n >= m_fire) && (edge_n < m_fire + int'(PW));
   endfunction

   task automatic model_edge(input logic r, input logic a, input logic ab,
                             input logic [RW-1:0] tg, input logic [RW-1:0] pd,
                             input logic [RW-1:0] rf, input logic v,
                             input logic [CW-1:0] tm);
      bit in_pulse;
      edge_n++;
      in_pulse = m_fv && (edge_n > m_fire) && (edge_n <= m_fire + int'(PW));
      if (r) begin
         m_armed = 0; m_done = 0; m_err = 0; m_fv = 0; m_tgt = '0; m_snap = '0;
      end else if (in_pulse) begin
         if (edge_n == m_fire + int'(PW)) m_done = 1;
      end else if (m_armed) begin
         if (ab) m_armed = 0;
         else if (v && rf == m_tgt) begin
            m_armed = 0; m_fv = 1; m_fire = edge_n; m_snap = tm;
         end
      end else if (a && !ab) begin
         m_done = 0;
         if (tg < pd) begin m_armed = 1; m_tgt = tg; m_err = 0; end
         else m_err = 1;
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare all outputs.
   task automatic step(input logic r, input logic a, input logic ab,
                       input logic [RW-1:0] tg, input logic [RW-1:0] pd,
                       input logic [RW-1:0] rf, input logic v);
      rst_i = r; arm_p_i = a; abort_p_i = ab; target_i = tg; period_i = pd;
      rf_cnt_i = rf; rf_cnt_valid_i = v; tm_cycles_i = tm_ctr;
      @(posedge clk_ref_i);
      model_edge(r, a, ab, tg, pd, rf, v, tm_ctr);
      tm_ctr = tm_ctr + CW'(1);
      @(negedge clk_ref_i);
      chk("trig",  32'(trig_p_o),   32'(m_trig()));
      chk("armed", 32'(armed_o),    32'(m_armed));
      chk("done",  32'(done_o),     32'(m_done));
      chk("error", 32'(error_o),    32'(m_err));
      chk("snap",  32'(snapshot_o), 32'(m_snap));
   endtask

   typedef struct {
      logic          rst;
      logic          arm;
      logic          abort;
      logic [RW-1:0] tgt;
      logic [3:0]    exp;   // {trig, armed, done, error}
   } vec_t;

   vec_t tbl[10];

   initial begin
      int            trig_cnt;
      logic [CW-1:0] match_tm;
      logic [RW-1:0] rf;
      logic [RW-1:0] pd;

      // period 512, rf parked at 300 so nothing below can match
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'd0,    4'b0000};  // reset
      tbl[1] = '{1'b0, 1'b1, 1'b0, 32'd1000, 4'b0001};  // target >= period
      tbl[2] = '{1'b0, 1'b0, 1'b0, 32'd0,    4'b0001};  // error sticky
      tbl[3] = '{1'b0, 1'b1, 1'b0, 32'd5,    4'b0100};  // good arm clears error
      tbl[4] = '{1'b0, 1'b0, 1'b0, 32'd0,    4'b0100};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 32'd0,    4'b0000};  // abort
      tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd5,    4'b0000};  // arm+abort in IDLE
      tbl[7] = '{1'b0, 1'b1, 1'b0, 32'd511,  4'b0100};  // boundary target
      tbl[8] = '{1'b0, 1'b1, 1'b1, 32'd5,    4'b0000};  // arm+abort in ARMED
      tbl[9] = '{1'b0, 1'b1, 1'b0, 32'd512,  4'b0001};  // target == period

      step(1'b1, 1'b0, 1'b0, '0, 32'd512, 32'd300, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].rst, tbl[i].arm, tbl[i].abort, tbl[i].tgt, 32'd512, 32'd300, 1'b1);
         chk($sformatf("tbl%0d", i), 32'({trig_p_o, armed_o, done_o, error_o}), 32'(tbl[i].exp));
      end
      // rejected arm never fires even when rf passes the rejected value
      trig_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'(i), 1'b1);
         if (trig_p_o) trig_cnt++;
      end
      chk("t1_no_pulse", 32'(trig_cnt), 32'd0);

      // Test 2: arm 123, rf counts from 100 with wrap
      step(1'b0, 1'b1, 1'b0, 32'd123, 32'd512, 32'd99, 1'b1);
      chk("t2_armed", 32'(armed_o), 32'd1);
      trig_cnt = 0; match_tm = '0;
      for (int i = 0; i < 40; i++) begin
         rf = 32'((100 + i) % 512);
         if (rf == 32'd123) match_tm = tm_ctr;
         step(1'b0, 1'b0, 1'b0, '0, 32'd512, rf, 1'b1);
         if (rf == 32'd123) chk("t2_first", 32'(trig_p_o), 32'd1);
         if (trig_p_o) trig_cnt++;
      end
      chk("t2_width", 32'(trig_cnt), PW);
      chk("t2_snap", 32'(snapshot_o), 32'(match_tm));
      chk("t2_done", 32'(done_o), 32'd1);

      // Test 3: arm 10, valid low on the first pass
      step(1'b0, 1'b1, 1'b0, 32'd10, 32'd512, 32'd0, 1'b1);
      trig_cnt = 0;
      for (int i = 1; i < 512; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'(i), (i > 300) ? 1'b1 : 1'b0);
         if (trig_p_o) trig_cnt++;
      end
      chk("t3_suppressed", 32'(trig_cnt), 32'd0);
      chk("t3_still_armed", 32'(armed_o), 32'd1);
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'(i), 1'b1);
         if (trig_p_o) trig_cnt++;
      end
      chk("t3_width", 32'(trig_cnt), PW);

      // Test 4: arm, abort before match
      step(1'b0, 1'b1, 1'b0, 32'd50, 32'd512, 32'd40, 1'b1);
      step(1'b0, 1'b0, 1'b1, '0, 32'd512, 32'd41, 1'b1);
      chk("t4_armed", 32'(armed_o), 32'd0);
      chk("t4_done", 32'(done_o), 32'd0);
      for (int i = 42; i < 60; i++) step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'(i), 1'b1);

      // Test 5: abort and re-arm during the pulse
      step(1'b0, 1'b1, 1'b0, 32'd200, 32'd512, 32'd195, 1'b1);
      trig_cnt = 0;
      for (int i = 196; i < 220; i++) begin
         step(1'b0, (i == 202) ? 1'b1 : 1'b0, (i >= 201 && i <= 203) ? 1'b1 : 1'b0,
              32'd210, 32'd512, 32'(i), 1'b1);
         if (trig_p_o) trig_cnt++;
      end
      chk("t5_width", 32'(trig_cnt), PW);
      chk("t5_idle", 32'(armed_o), 32'd0);
      chk("t5_done", 32'(done_o), 32'd1);

      // Test 6: reset on the 3rd pulse cycle
      step(1'b0, 1'b1, 1'b0, 32'd7, 32'd512, 32'd5, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'd6, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'd7, 1'b1);   // pulse cycle 1
      step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'd8, 1'b1);   // pulse cycle 2
      chk("t6_mid", 32'(trig_p_o), 32'd1);
      step(1'b1, 1'b0, 1'b0, '0, 32'd512, 32'd9, 1'b1);   // reset in cycle 3
      chk("t6_rst", 32'({trig_p_o, armed_o, done_o, error_o}), 32'd0);
      chk("t6_snap", 32'(snapshot_o), 32'd0);
      for (int i = 10; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, 32'd512, 32'(i), 1'b1);

      // Randomized traffic against the model
      pd = 32'd12; rf = '0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 400 == 0) begin pd = 32'(8 + $urandom_range(0, 12)); rf = '0; end
         step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
              32'($urandom_range(0, 32'(pd) + 2)), pd, rf,
              ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
         rf = (rf == pd - 32'd1) ? '0 : rf + 32'd1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
